cascade_timer_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter for the stopwatch/timer datapath, generalising the single-digit mod-10 down counter. Each digit has its own radix, so one instance counts plain decimal (0000–9999) or clock time (mm:ss, 00:00–59:59). It advances on a one-cycle `tick` strobe from the clock divider and counts up (stopwatch) or down (countdown timer). It provides a parallel load, selectable wrap or halt at the terminal value, and terminal-count and done flags consumed by the control FSM and the display mux.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/bcd_digit_cell.sv | 54 +++++
 rtl/cascade_timer_counter.sv | 105 ++++++++++
 tb/tb_cascade_timer_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch/timer datapath.
// Digit width, the common radix vectors, and the clamp applied to loaded digits.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [15:0] RADIX_DEC4 = 16'h9999;
    localparam logic [15:0] RADIX_MMSS = 16'h5959;

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] v,
        input logic [DIGIT_W-1:0] max_v
    );
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with programmable maximum: up/down step with carry/borrow wrap,
// clamped parallel load, and zero/max flags for both the current and next value.
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX    = 4'd9,
    parameter logic [DIGIT_W-1:0] INIT_V = 4'd0
) (
    input  logic               clk,
    input  logic               r_n,
    input  logic               en,
    input  logic               dir,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               at_zero,
    output logic               at_max,
    output logic               nxt_zero,
    output logic               nxt_max
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    assign at_zero = (digit_q == '0);
    assign at_max  = (digit_q == MAX);

    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = clamp_digit(ld_val, MAX);
        end else if (en) begin
            if (dir) begin
                digit_d = at_max ? '0 : digit_q + 4'd1;
            end else begin
                digit_d = at_zero ? MAX : digit_q - 4'd1;
            end
        end
    end

    // Next-value flags let the top detect the terminal on the stepping edge itself.
    assign nxt_zero = (digit_d == '0);
    assign nxt_max  = (digit_d == MAX);
    assign digit    = digit_q;

    always_ff @(posedge clk) begin
        if (!r_n) begin
            digit_q <= INIT_V;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/cascade_timer_counter.sv
// Multi-digit BCD up/down counter with per-digit radix, parallel load,
// wrap/halt at the terminal value, and registered terminal-count / done flags.
module cascade_timer_counter
    import stopwatch_pkg::*;
#(
    parameter int                      DIGITS    = 4,
    parameter logic [4*DIGITS-1:0]     RADIX_VEC = 16'h9999,
    parameter logic [4*DIGITS-1:0]     INIT      = '0
) (
    input  logic                  clk,
    input  logic                  r_n,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  wrap,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  done
);

    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] nxt_zero;
    logic [DIGITS-1:0] nxt_max;
    logic              step;
    logic              term_next;
    logic              tc_q;
    logic              tc_d;
    logic              done_q;
    logic              done_d;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("cascade_timer_counter: DIGITS must be 1..8");
    end

    // Load wins over a coincident tick, so the step is suppressed outright.
    assign step = run & tick & ~done_q & ~load;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        localparam logic [DIGIT_W-1:0] MAX_G  = RADIX_VEC[gi*DIGIT_W +: DIGIT_W];
        localparam logic [DIGIT_W-1:0] INIT_G = INIT[gi*DIGIT_W +: DIGIT_W];

        if (MAX_G == 4'd0 || MAX_G > 4'd9) begin : g_bad_radix
            $error("cascade_timer_counter: digit max must be 1..9");
        end
        if (INIT_G > MAX_G) begin : g_bad_init
            $error("cascade_timer_counter: INIT digit exceeds its max");
        end

        if (gi == 0) begin : g_first
            assign en[gi] = step;
        end else begin : g_chain
            assign en[gi] = en[gi-1] & (dir ? at_max[gi-1] : at_zero[gi-1]);
        end

        bcd_digit_cell #(
            .MAX    (MAX_G),
            .INIT_V (INIT_G)
        ) u_cell (
            .clk      (clk),
            .r_n      (r_n),
            .en       (en[gi]),
            .dir      (dir),
            .ld       (load),
            .ld_val   (load_val[gi*DIGIT_W +: DIGIT_W]),
            .digit    (count[gi*DIGIT_W +: DIGIT_W]),
            .at_zero  (at_zero[gi]),
            .at_max   (at_max[gi]),
            .nxt_zero (nxt_zero[gi]),
            .nxt_max  (nxt_max[gi])
        );
    end

    assign term_next = dir ? (&nxt_max) : (&nxt_zero);

    always_comb begin
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            done_d = 1'b0;
        end else if (step && term_next) begin
            tc_d = 1'b1;
            if (!wrap) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!r_n) begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign tc   = tc_q;
    assign done = done_q;

endmodule

// File: tb/tb_cascade_timer_counter.sv
// Bench for cascade_timer_counter in the mm:ss configuration: a seconds-based
// reference model feeds a scoreboard, and each scenario task adds targeted checks.
module tb_cascade_timer_counter;
    import stopwatch_pkg::*;

    logic        clk = 1'b0;
    logic        r_n = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        wrap = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        tc;
    logic        done;

    int checks = 0;
    int failures = 0;
    bit verbose = 1'b1;

    logic [17:0] sb[$];
    int m_secs = 0;
    bit m_tc = 1'b0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    cascade_timer_counter #(
        .DIGITS    (4),
        .RADIX_VEC (RADIX_MMSS),
        .INIT      (16'h0000)
    ) dut (
        .clk      (clk),
        .r_n      (r_n),
        .tick     (tick),
        .run      (run),
        .dir      (dir),
        .wrap     (wrap),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int clamp_secs(input logic [15:0] v);
        int n3, n2, n1, n0;
        n3 = (v[15:12] > 4'd5) ? 5 : int'(v[15:12]);
        n2 = (v[11:8]  > 4'd9) ? 9 : int'(v[11:8]);
        n1 = (v[7:4]   > 4'd5) ? 5 : int'(v[7:4]);
        n0 = (v[3:0]   > 4'd9) ? 9 : int'(v[3:0]);
        return (n3 * 10 + n2) * 60 + n1 * 10 + n0;
    endfunction

    // Reference behaviour for the inputs currently on the pins; result goes to the scoreboard.
    task automatic model_apply();
        if (!r_n) begin
            m_secs = 0;
            m_tc   = 1'b0;
            m_done = 1'b0;
        end else if (load) begin
            m_secs = clamp_secs(load_val);
            m_tc   = 1'b0;
            m_done = 1'b0;
        end else if (run && tick && !m_done) begin
            m_secs = dir ? (m_secs + 1) % 3600 : (m_secs + 3599) % 3600;
            m_tc   = (m_secs == (dir ? 3599 : 0));
            if (m_tc && !wrap) m_done = 1'b1;
        end else begin
            m_tc = 1'b0;
        end
        sb.push_back({to_bcd(m_secs), m_tc, m_done});
    endtask

    task automatic drive(input logic rn, input logic t, input logic rr, input logic d,
                         input logic w, input logic ld, input logic [15:0] lv);
        @(negedge clk);
        r_n = rn; tick = t; run = rr; dir = d; wrap = w; load = ld; load_val = lv;
        model_apply();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        logic [17:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                checks++;
                if ({count, tc, done} !== exp_v) begin
                    failures++;
                    $display("FAIL scoreboard: got count=%h tc=%b done=%b, want count=%h tc=%b done=%b",
                             count, tc, done, exp_v[17:2], exp_v[1], exp_v[0]);
                end else if (verbose) begin
                    $display("txn t=%0t count=%h tc=%b done=%b", $time, count, tc, done);
                end
            end
        end
    end

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0000) begin failures++; $display("FAIL reset_count: got %h want 0000", count); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc: got %b want 0", tc); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_mmss_sweep();
        verbose = 1'b0;
        for (int i = 1; i <= 3599; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            if (i == 3598) begin
                checks++; if (tc !== 1'b0) begin failures++; $display("FAIL sweep_tc_early: got %b want 0", tc); end
            end
        end
        verbose = 1'b1;
        checks++; if (count !== 16'h5959) begin failures++; $display("FAIL sweep_5959: got %h want 5959", count); end
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL sweep_tc: got %b want 1", tc); end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL sweep_tc_one_cycle: got %b want 0", tc); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0000 || tc !== 1'b0) begin
            failures++; $display("FAIL sweep_wrap: got count=%h tc=%b want 0000/0", count, tc);
        end
    endtask

    task automatic test_countdown_halt();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0059) begin failures++; $display("FAIL down_borrow: got %h want 0059", count); end
        for (int i = 2; i <= 59; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0000 || tc !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL down_terminal: got count=%h tc=%b done=%b want 0000/1/1", count, tc, done);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0000 || tc !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL down_hold: got count=%h tc=%b done=%b want 0000/0/1", count, tc, done);
        end
    endtask

    task automatic test_reload();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
        checks++; if (done !== 1'b0 || count !== 16'h0005) begin
            failures++; $display("FAIL reload_done: got count=%h done=%b want 0005/0", count, done);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0000 || tc !== 1'b1) begin
            failures++; $display("FAIL reload_terminal: got count=%h tc=%b want 0000/1", count, tc);
        end
    endtask

    task automatic test_load_clamp();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF9F9);
        checks++; if (count !== 16'h5959) begin failures++; $display("FAIL clamp: got %h want 5959", count); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0123);
        checks++; if (count !== 16'h0123 || tc !== 1'b0) begin
            failures++; $display("FAIL load_tick: got count=%h tc=%b want 0123/0", count, tc);
        end
    endtask

    task automatic test_dir_change();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0458);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0459) begin failures++; $display("FAIL dir_up: got %h want 0459", count); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0458) begin failures++; $display("FAIL dir_flip: got %h want 0458", count); end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        checks++; if (count !== 16'h0458) begin failures++; $display("FAIL run_low: got %h want 0458", count); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (count !== 16'h5959 || tc !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL wrap_from_load: got count=%h tc=%b done=%b want 5959/0/0", count, tc, done);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0012);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        r_n = 1'b0; tick = 1'b1; load = 1'b1; load_val = 16'h0345;
        #1;
        checks++; if (count !== 16'h0011) begin failures++; $display("FAIL reset_no_edge: got %h want 0011", count); end
        model_apply();
        @(posedge clk);
        #2;
        checks++; if (count !== 16'h0000 || tc !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_mid: got count=%h tc=%b done=%b want 0000/0/0", count, tc, done);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_mmss_sweep();
        test_countdown_halt();
        test_reload();
        test_load_clamp();
        test_dir_change();
        test_mid_reset();
        @(negedge clk);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
